// File: rtl/muldiv_pkg.sv
// Shared operation codes and FSM encoding for the multiply/divide unit.
// The ALU codes match what the decoder drives on ALUControl.
package muldiv_pkg;

    localparam logic [3:0] ALU_MUL   = 4'b0100;
    localparam logic [3:0] ALU_UMULL = 4'b0110;
    localparam logic [3:0] ALU_DIV   = 4'b0111;
    localparam logic [3:0] ALU_SMULL = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic op_supported(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_UMULL) ||
               (op == ALU_DIV) || (op == ALU_SMULL);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider.
// One bit per cycle; fixed WIDTH+2 cycle latency from start to done.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       Flags,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         op;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               neg;

    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     drem;
    logic [WIDTH:0]     ddiff;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic [1:0]         fix_flags;
    logic               is_div;
    logic               is_long;

    assign accept = (state == S_IDLE) && start && !flush &&
                    op_supported(ALUControl);
    assign last   = (count == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; flush aborts any active state
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (accept) state_nxt = S_CALC;
            S_CALC: begin
                if (flush)     state_nxt = S_IDLE;
                else if (last) state_nxt = S_FIX;
            end
            S_FIX:  state_nxt = flush ? S_IDLE : S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; a flush in DONE swallows the pulse
    always_comb begin
        busy = (state == S_CALC) || (state == S_FIX);
        done = (state == S_DONE) && !flush;
    end

    // Operand magnitudes at launch; -MIN stays exact as unsigned
    always_comb begin
        a_abs = SrcA;
        b_abs = SrcB;
        if (ALUControl == ALU_SMULL && SrcA[WIDTH-1]) a_abs = -SrcA;
        if (ALUControl == ALU_SMULL && SrcB[WIDTH-1]) b_abs = -SrcB;
    end

    // One iteration: acc holds {partial, multiplier} or {rem, quotient}
    always_comb begin
        mul_add = acc[0] ? opnd : {WIDTH{1'b0}};
        msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        drem    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ddiff   = drem - {1'b0, opnd};
        if (op == ALU_DIV) begin
            if (ddiff[WIDTH])
                acc_step = {drem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_step = {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {msum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction, result select and flags for the FIX cycle
    always_comb begin
        is_div    = (op == ALU_DIV);
        is_long   = (op == ALU_UMULL) || (op == ALU_SMULL);
        prod      = neg ? -acc : acc;
        fix_hi    = '0;
        fix_lo    = prod[WIDTH-1:0];
        fix_flags = {fix_lo[WIDTH-1], fix_lo == '0};
        unique case (1'b1)
            is_div: begin
                fix_hi    = acc[2*WIDTH-1:WIDTH];
                fix_lo    = acc[WIDTH-1:0];
                fix_flags = {fix_lo[WIDTH-1], fix_lo == '0};
            end
            is_long: begin
                fix_hi    = prod[2*WIDTH-1:WIDTH];
                fix_lo    = prod[WIDTH-1:0];
                fix_flags = {fix_hi[WIDTH-1], prod == '0};
            end
            default: begin
                fix_hi    = '0;
                fix_lo    = prod[WIDTH-1:0];
                fix_flags = {fix_lo[WIDTH-1], fix_lo == '0};
            end
        endcase
    end

    // Datapath registers; results only change on a completed FIX
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op       <= '0;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            neg      <= 1'b0;
            ResultHi <= '0;
            ResultLo <= '0;
            Flags    <= '0;
            DivZero  <= 1'b0;
        end else if (accept) begin
            op    <= ALUControl;
            count <= '0;
            neg   <= (ALUControl == ALU_SMULL) &&
                     (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            if (ALUControl == ALU_DIV) begin
                opnd <= SrcB;
                acc  <= {{WIDTH{1'b0}}, SrcA};
            end else begin
                opnd <= a_abs;
                acc  <= {{WIDTH{1'b0}}, b_abs};
            end
        end else if (state == S_CALC && !flush) begin
            acc   <= acc_step;
            count <= count + CW'(1);
        end else if (state == S_FIX && !flush) begin
            ResultHi <= fix_hi;
            ResultLo <= fix_lo;
            Flags    <= fix_flags;
            DivZero  <= is_div && (opnd == '0);
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit.
// Expected results are queued at launch and popped at done.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [1:0]  fl;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  ALUControl = '0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        busy;
    logic        done;
    logic [31:0] ResultLo;
    logic [31:0] ResultHi;
    logic [1:0]  Flags;
    logic        DivZero;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
        .busy(busy), .done(done), .ResultLo(ResultLo),
        .ResultHi(ResultHi), .Flags(Flags), .DivZero(DivZero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        e = '0;
        p = '0;
        case (op)
            ALU_MUL: begin
                p = {32'b0, a} * {32'b0, b};
                e.lo = p[31:0];
                e.fl = {e.lo[31], e.lo == 0};
            end
            ALU_UMULL, ALU_SMULL: begin
                if (op == ALU_UMULL) p = {32'b0, a} * {32'b0, b};
                else p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.fl = {p[63], p == 0};
            end
            default: begin
                if (b == 0) begin
                    e.lo = 32'hFFFFFFFF;
                    e.hi = a;
                    e.dz = 1'b1;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
                e.fl = {e.lo[31], e.lo == 0};
            end
        endcase
        return e;
    endfunction

    task automatic launch(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clk);
        ALUControl = op; SrcA = a; SrcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // cyc counts the start edge as 1; -1 on timeout
    task automatic run(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e,
                       output int cyc);
        sb.push_back(e);
        launch(op, a, b);
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, DivZero, Flags, ResultHi, ResultLo} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b/%b/%b/%b/%h/%h want all 0",
                     busy, done, DivZero, Flags, ResultHi, ResultLo);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_umull();
        exp_t e;
        int cyc;
        run(ALU_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF,
            exp_t'{32'hFFFFFFFE, 32'h00000001, 2'b10, 1'b0}, cyc);
        e = sb.pop_front();
        checks++;
        if (cyc !== 34) begin
            errors++;
            $display("FAIL umull_latency: got %0d want 34", cyc);
        end
        checks++;
        if ({ResultHi, ResultLo, Flags, DivZero} !== e) begin
            errors++;
            $display("FAIL umull_result: got %h %h %b %b want %h %h %b %b",
                     ResultHi, ResultLo, Flags, DivZero, e.hi, e.lo, e.fl, e.dz);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_width: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_smull();
        logic [31:0] a[2] = '{32'hFFFFFFFE, 32'h80000000};
        logic [31:0] b[2] = '{32'h00000003, 32'h80000000};
        exp_t ev[2] = '{exp_t'{32'hFFFFFFFF, 32'hFFFFFFFA, 2'b10, 1'b0},
                        exp_t'{32'h40000000, 32'h00000000, 2'b00, 1'b0}};
        exp_t e;
        int cyc;
        for (int i = 0; i < 2; i++) begin
            run(ALU_SMULL, a[i], b[i], ev[i], cyc);
            e = sb.pop_front();
            checks++;
            if (cyc !== 34 || {ResultHi, ResultLo, Flags, DivZero} !== e) begin
                errors++;
                $display("FAIL smull_%0d: got %h %h %b cyc=%0d want %h %h %b cyc=34",
                         i, ResultHi, ResultLo, Flags, cyc, e.hi, e.lo, e.fl);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] a[2] = '{32'd100, 32'd5};
        logic [31:0] b[2] = '{32'd7, 32'd0};
        exp_t ev[2] = '{exp_t'{32'h00000002, 32'h0000000E, 2'b00, 1'b0},
                        exp_t'{32'h00000005, 32'hFFFFFFFF, 2'b10, 1'b1}};
        exp_t e;
        int cyc;
        for (int i = 0; i < 2; i++) begin
            run(ALU_DIV, a[i], b[i], ev[i], cyc);
            e = sb.pop_front();
            checks++;
            if (cyc !== 34) begin
                errors++;
                $display("FAIL div_latency_%0d: got %0d want 34", i, cyc);
            end
            checks++;
            if ({ResultHi, ResultLo, Flags, DivZero} !== e) begin
                errors++;
                $display("FAIL div_%0d: got %h %h %b %b want %h %h %b %b", i,
                         ResultHi, ResultLo, Flags, DivZero, e.hi, e.lo, e.fl, e.dz);
            end
        end
    endtask

    task automatic test_mul();
        logic [31:0] a[2] = '{32'h00010000, 32'd7};
        logic [31:0] b[2] = '{32'h00010000, 32'd6};
        exp_t ev[2] = '{exp_t'{32'h0, 32'h0, 2'b01, 1'b0},
                        exp_t'{32'h0, 32'h2A, 2'b00, 1'b0}};
        exp_t e;
        int cyc;
        for (int i = 0; i < 2; i++) begin
            run(ALU_MUL, a[i], b[i], ev[i], cyc);
            e = sb.pop_front();
            checks++;
            if (cyc !== 34 || {ResultHi, ResultLo, Flags, DivZero} !== e) begin
                errors++;
                $display("FAIL mul_%0d: got %h %h %b cyc=%0d want %h %h %b cyc=34",
                         i, ResultHi, ResultLo, Flags, cyc, e.hi, e.lo, e.fl);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] ops[4] = '{ALU_MUL, ALU_UMULL, ALU_DIV, ALU_SMULL};
        logic [3:0] op;
        logic [31:0] a, b;
        exp_t e;
        int cyc;
        for (int i = 0; i < 12; i++) begin
            op = ops[$urandom_range(0, 3)];
            a = $urandom();
            b = (i % 4 == 3) ? 32'($urandom_range(0, 15)) : $urandom();
            run(op, a, b, model(op, a, b), cyc);
            e = sb.pop_front();
            checks++;
            if (cyc !== 34 || {ResultHi, ResultLo, Flags, DivZero} !== e) begin
                errors++;
                $display("FAIL random_%0d op=%b a=%h b=%h: got %h %h %b %b cyc=%0d want %h %h %b %b",
                         i, op, a, b, ResultHi, ResultLo, Flags, DivZero, cyc,
                         e.hi, e.lo, e.fl, e.dz);
            end
        end
    endtask

    task automatic test_unsupported();
        int dones = 0;
        launch(4'b0000, 32'd1, 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL unsupported_op: got %0d active cycles want 0", dones);
        end
    endtask

    task automatic test_start_flush();
        exp_t e;
        int dones = 0;
        int cyc;
        sb.push_back(exp_t'{32'h0, 32'h2A, 2'b00, 1'b0});
        launch(ALU_MUL, 32'd7, 32'd6);
        SrcA = 32'd9; SrcB = 32'd9; ALUControl = ALU_UMULL;
        for (int i = 0; i < 60; i++) begin
            start = (i == 5 || i == 20 || i == 32 || i == 33);
            if (done) begin
                dones++;
                if (dones == 1) begin
                    e = sb.pop_front();
                    checks++;
                    if ({ResultHi, ResultLo, Flags, DivZero} !== e) begin
                        errors++;
                        $display("FAIL busy_start_result: got %h %h want %h %h",
                                 ResultHi, ResultLo, e.hi, e.lo);
                    end
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL busy_start_ignored: got %0d dones want 1", dones);
        end
        launch(ALU_UMULL, 32'd5, 32'd5);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0 || busy !== 1'b0 || ResultLo !== 32'h2A) begin
            errors++;
            $display("FAIL flush: got dones=%0d busy=%b lo=%h want 0 0 0000002a",
                     dones, busy, ResultLo);
        end
        run(ALU_UMULL, 32'd3, 32'd4, exp_t'{32'h0, 32'hC, 2'b00, 1'b0}, cyc);
        e = sb.pop_front();
        checks++;
        if (cyc !== 34 || {ResultHi, ResultLo, Flags, DivZero} !== e) begin
            errors++;
            $display("FAIL after_flush: got %h %h cyc=%0d want %h %h cyc=34",
                     ResultHi, ResultLo, cyc, e.hi, e.lo);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int cyc;
        launch(ALU_UMULL, 32'hFFFF0000, 32'h12345678);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, DivZero, Flags, ResultHi, ResultLo} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got %b/%b/%b/%b/%h/%h want all 0",
                     busy, done, DivZero, Flags, ResultHi, ResultLo);
        end
        @(negedge clk);
        reset = 1'b1;
        run(ALU_DIV, 32'd9, 32'd3, exp_t'{32'h0, 32'h3, 2'b00, 1'b0}, cyc);
        e = sb.pop_front();
        checks++;
        if (cyc !== 34 || {ResultHi, ResultLo, Flags, DivZero} !== e) begin
            errors++;
            $display("FAIL after_reset: got %h %h cyc=%0d want %h %h cyc=34",
                     ResultHi, ResultLo, cyc, e.hi, e.lo);
        end
    endtask

    initial begin
        test_reset();
        test_umull();
        test_smull();
        test_div();
        test_mul();
        test_random();
        test_unsupported();
        test_start_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
